// File: rtl/sw_debounce_pkg.sv
// Shared constants and width helper for the switch debouncer.
// Optional reset generator is enabled with SW_DEBOUNCE_RESETGEN_EN.
package sw_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;
    localparam int DEFAULT_RESET_HOLD      = 16;

    // Counter width for a counter that must reach n-1; never narrower than 1 bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sw_debounce_if.sv
// Switch-conditioner bundle: raw pins in, clean levels and edge pulses out.
// core_resetn_o exists only when SW_DEBOUNCE_RESETGEN_EN is defined.
interface sw_debounce_if #(
    parameter int N_SW = 4
);
    logic [N_SW-1:0] sw_i;
    logic [N_SW-1:0] sw_o;
    logic [N_SW-1:0] rise_o;
    logic [N_SW-1:0] fall_o;
    logic            changed_o;
`ifdef SW_DEBOUNCE_RESETGEN_EN
    logic            core_resetn_o;

    modport master (input sw_i, output sw_o, rise_o, fall_o, changed_o, core_resetn_o);
    modport slave  (output sw_i, input sw_o, rise_o, fall_o, changed_o, core_resetn_o);
`else
    modport master (input sw_i, output sw_o, rise_o, fall_o, changed_o);
    modport slave  (output sw_i, input sw_o, rise_o, fall_o, changed_o);
`endif
endinterface

// File: rtl/sw_debounce_bit.sv
// One switch bit: two-flop synchroniser, stability counter, stable level
// and one-cycle rise/fall pulses coincident with the level change.
module sw_debounce_bit
    import sw_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic resetn,
    input  logic sw_i,
    output logic sw_o,
    output logic rise_o,
    output logic fall_o
);
    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] TERMINAL = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_reg, s2_reg;
    logic          stable_reg, stable_next;
    logic          rise_reg, rise_next;
    logic          fall_reg, fall_next;
    logic [CW-1:0] cnt_reg, cnt_next;

    always_comb begin
        stable_next = stable_reg;
        rise_next   = 1'b0;
        fall_next   = 1'b0;
        cnt_next    = cnt_reg;
        if (s2_reg == stable_reg) begin
            // Any return to the accepted level abandons the attempt.
            cnt_next = '0;
        end else if (cnt_reg == TERMINAL) begin
            stable_next = s2_reg;
            rise_next   = s2_reg;
            fall_next   = ~s2_reg;
            cnt_next    = '0;
        end else begin
            cnt_next = cnt_reg + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_reg     <= 1'b0;
            s2_reg     <= 1'b0;
            stable_reg <= 1'b0;
            rise_reg   <= 1'b0;
            fall_reg   <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            s1_reg     <= sw_i;
            s2_reg     <= s1_reg;
            stable_reg <= stable_next;
            rise_reg   <= rise_next;
            fall_reg   <= fall_next;
            cnt_reg    <= cnt_next;
        end
    end

    assign sw_o   = stable_reg;
    assign rise_o = rise_reg;
    assign fall_o = fall_reg;

endmodule

// File: rtl/sw_debounce.sv
// Board switch conditioner: N_SW independent debounced bits plus changed_o.
// Define SW_DEBOUNCE_RESETGEN_EN to add the stretched core_resetn_o from sw_o[0].
module sw_debounce
    import sw_pkg::*;
#(
    parameter int N_SW            = 4,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int RESET_HOLD      = DEFAULT_RESET_HOLD
) (
    input  logic          clk,
    input  logic          resetn,
    sw_debounce_if.master bus
);
    logic [N_SW-1:0] sw_w;
    logic [N_SW-1:0] rise_w;
    logic [N_SW-1:0] fall_w;

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 2");
    end
    if (RESET_HOLD < 1) begin : g_bad_hold
        $error("RESET_HOLD must be at least 1");
    end

    generate
        for (genvar gi = 0; gi < N_SW; gi++) begin : g_bit
            sw_debounce_bit #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_bit (
                .clk    (clk),
                .resetn (resetn),
                .sw_i   (bus.sw_i[gi]),
                .sw_o   (sw_w[gi]),
                .rise_o (rise_w[gi]),
                .fall_o (fall_w[gi])
            );
        end
    endgenerate

    assign bus.sw_o      = sw_w;
    assign bus.rise_o    = rise_w;
    assign bus.fall_o    = fall_w;
    assign bus.changed_o = |(rise_w | fall_w);

`ifdef SW_DEBOUNCE_RESETGEN_EN
    localparam int            HW       = cnt_width(RESET_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(RESET_HOLD);

    logic [HW-1:0] hold_reg, hold_next;

    always_comb begin
        hold_next = hold_reg;
        if (!sw_w[0]) begin
            hold_next = '0;
        end else if (hold_reg != HOLD_MAX) begin
            hold_next = hold_reg + HW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hold_reg <= '0;
        end else begin
            hold_reg <= hold_next;
        end
    end

    // Gating with the stable level drops core reset on the same edge as fall_o[0].
    assign bus.core_resetn_o = sw_w[0] && (hold_reg == HOLD_MAX);
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with DEBOUNCE_CYCLES=4, RESET_HOLD=3.
// Inputs change 1ns after a rising edge; outputs are sampled at the same point.
module tb_sw_debounce;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    sw_debounce_if #(.N_SW(4)) bus ();

    sw_debounce #(
        .N_SW(4),
        .DEBOUNCE_CYCLES(4),
        .RESET_HOLD(3)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        bus.sw_i = 4'hF;
        resetn   = 1'b0;
        tick(2);
        checks++;
        if (bus.sw_o !== 4'h0 || bus.rise_o !== 4'h0 || bus.fall_o !== 4'h0 || bus.changed_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got sw=%h rise=%h fall=%h chg=%b want all 0",
                     bus.sw_o, bus.rise_o, bus.fall_o, bus.changed_o);
        end
`ifdef SW_DEBOUNCE_RESETGEN_EN
        checks++;
        if (bus.core_resetn_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_core_resetn got %b want 0", bus.core_resetn_o);
        end
`endif
        resetn = 1'b1;
        tick(5);
        checks++;
        if (bus.sw_o !== 4'h0 || bus.rise_o !== 4'h0) begin
            errors++;
            $display("FAIL powerup_early got sw=%h rise=%h want 0 0", bus.sw_o, bus.rise_o);
        end
        tick(1);
        checks++;
        if (bus.sw_o !== 4'hF || bus.rise_o !== 4'hF || bus.changed_o !== 1'b1) begin
            errors++;
            $display("FAIL powerup_rise got sw=%h rise=%h chg=%b want F F 1",
                     bus.sw_o, bus.rise_o, bus.changed_o);
        end
        tick(1);
        checks++;
        if (bus.sw_o !== 4'hF || bus.rise_o !== 4'h0 || bus.changed_o !== 1'b0) begin
            errors++;
            $display("FAIL powerup_pulse_end got sw=%h rise=%h chg=%b want F 0 0",
                     bus.sw_o, bus.rise_o, bus.changed_o);
        end
        bus.sw_i = 4'h0;
        tick(6);
        checks++;
        if (bus.sw_o !== 4'h0 || bus.fall_o !== 4'hF || bus.rise_o !== 4'h0) begin
            errors++;
            $display("FAIL powerup_fall got sw=%h fall=%h rise=%h want 0 F 0",
                     bus.sw_o, bus.fall_o, bus.rise_o);
        end
        tick(1);
        $display("test_reset done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_clean_edge();
        bus.sw_i = 4'h2;
        tick(5);
        checks++;
        if (bus.sw_o !== 4'h0 || bus.rise_o !== 4'h0) begin
            errors++;
            $display("FAIL clean_rise_early got sw=%h rise=%h want 0 0", bus.sw_o, bus.rise_o);
        end
        tick(1);
        checks++;
        if (bus.sw_o !== 4'h2 || bus.rise_o !== 4'h2 || bus.fall_o !== 4'h0 || bus.changed_o !== 1'b1) begin
            errors++;
            $display("FAIL clean_rise got sw=%h rise=%h fall=%h chg=%b want 2 2 0 1",
                     bus.sw_o, bus.rise_o, bus.fall_o, bus.changed_o);
        end
        tick(1);
        checks++;
        if (bus.rise_o !== 4'h0 || bus.changed_o !== 1'b0) begin
            errors++;
            $display("FAIL clean_rise_single got rise=%h chg=%b want 0 0", bus.rise_o, bus.changed_o);
        end
        bus.sw_i = 4'h0;
        tick(5);
        checks++;
        if (bus.sw_o !== 4'h2 || bus.fall_o !== 4'h0) begin
            errors++;
            $display("FAIL clean_fall_early got sw=%h fall=%h want 2 0", bus.sw_o, bus.fall_o);
        end
        tick(1);
        checks++;
        if (bus.sw_o !== 4'h0 || bus.fall_o !== 4'h2 || bus.rise_o !== 4'h0 || bus.changed_o !== 1'b1) begin
            errors++;
            $display("FAIL clean_fall got sw=%h fall=%h rise=%h chg=%b want 0 2 0 1",
                     bus.sw_o, bus.fall_o, bus.rise_o, bus.changed_o);
        end
        tick(1);
        checks++;
        if (bus.fall_o !== 4'h0) begin
            errors++;
            $display("FAIL clean_fall_single got fall=%h want 0", bus.fall_o);
        end
        $display("test_clean_edge done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_glitch();
        logic [6:0] pattern;
        bus.sw_i = 4'h4;
        tick(3);
        bus.sw_i = 4'h0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            checks++;
            if (bus.sw_o !== 4'h0 || bus.rise_o !== 4'h0) begin
                errors++;
                $display("FAIL glitch_reject cycle %0d got sw=%h rise=%h want 0 0",
                         i, bus.sw_o, bus.rise_o);
            end
        end
        // Applied oldest first: 1,0,1,1,1,1,1; last 0->1 is element 2.
        pattern = 7'b1111101;
        for (int i = 0; i < 7; i++) begin
            bus.sw_i = {1'b0, pattern[i], 2'b00};
            tick(1);
        end
        checks++;
        if (bus.sw_o !== 4'h0) begin
            errors++;
            $display("FAIL bounce_early got sw=%h want 0", bus.sw_o);
        end
        tick(1);
        checks++;
        if (bus.sw_o !== 4'h4 || bus.rise_o !== 4'h4) begin
            errors++;
            $display("FAIL bounce_rise got sw=%h rise=%h want 4 4", bus.sw_o, bus.rise_o);
        end
        bus.sw_i = 4'h0;
        tick(6);
        checks++;
        if (bus.sw_o !== 4'h0 || bus.fall_o !== 4'h4) begin
            errors++;
            $display("FAIL bounce_fall got sw=%h fall=%h want 0 4", bus.sw_o, bus.fall_o);
        end
        tick(1);
        $display("test_glitch done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_simultaneous();
        bus.sw_i = 4'h5;
        tick(5);
        checks++;
        if (bus.rise_o !== 4'h0 || bus.changed_o !== 1'b0) begin
            errors++;
            $display("FAIL simul_early got rise=%h chg=%b want 0 0", bus.rise_o, bus.changed_o);
        end
        tick(1);
        checks++;
        if (bus.sw_o !== 4'h5 || bus.rise_o !== 4'h5 || bus.changed_o !== 1'b1) begin
            errors++;
            $display("FAIL simul_rise got sw=%h rise=%h chg=%b want 5 5 1",
                     bus.sw_o, bus.rise_o, bus.changed_o);
        end
        tick(1);
        checks++;
        if (bus.rise_o !== 4'h0 || bus.changed_o !== 1'b0) begin
            errors++;
            $display("FAIL simul_single got rise=%h chg=%b want 0 0", bus.rise_o, bus.changed_o);
        end
        bus.sw_i = 4'h0;
        tick(6);
        checks++;
        if (bus.sw_o !== 4'h0 || bus.fall_o !== 4'h5 || bus.changed_o !== 1'b1) begin
            errors++;
            $display("FAIL simul_fall got sw=%h fall=%h chg=%b want 0 5 1",
                     bus.sw_o, bus.fall_o, bus.changed_o);
        end
        tick(1);
        $display("test_simultaneous done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_reset_mid_count();
        bus.sw_i = 4'h8;
        tick(3);
        resetn = 1'b0;
        tick(1);
        checks++;
        if (bus.sw_o !== 4'h0 || bus.rise_o !== 4'h0) begin
            errors++;
            $display("FAIL midreset_held got sw=%h rise=%h want 0 0", bus.sw_o, bus.rise_o);
        end
        resetn = 1'b1;
        tick(5);
        checks++;
        if (bus.sw_o !== 4'h0) begin
            errors++;
            $display("FAIL midreset_early got sw=%h want 0", bus.sw_o);
        end
        tick(1);
        checks++;
        if (bus.sw_o !== 4'h8 || bus.rise_o !== 4'h8) begin
            errors++;
            $display("FAIL midreset_rise got sw=%h rise=%h want 8 8", bus.sw_o, bus.rise_o);
        end
        bus.sw_i = 4'h0;
        tick(7);
        $display("test_reset_mid_count done checks=%0d errors=%0d", checks, errors);
    endtask

`ifdef SW_DEBOUNCE_RESETGEN_EN
    task automatic test_resetgen();
        bus.sw_i = 4'h1;
        tick(6);
        checks++;
        if (bus.sw_o !== 4'h1 || bus.core_resetn_o !== 1'b0) begin
            errors++;
            $display("FAIL resetgen_rise got sw=%h core=%b want 1 0", bus.sw_o, bus.core_resetn_o);
        end
        tick(2);
        checks++;
        if (bus.core_resetn_o !== 1'b0) begin
            errors++;
            $display("FAIL resetgen_hold got core=%b want 0", bus.core_resetn_o);
        end
        tick(1);
        checks++;
        if (bus.core_resetn_o !== 1'b1) begin
            errors++;
            $display("FAIL resetgen_release got core=%b want 1", bus.core_resetn_o);
        end
        bus.sw_i = 4'h0;
        tick(5);
        checks++;
        if (bus.core_resetn_o !== 1'b1) begin
            errors++;
            $display("FAIL resetgen_early_assert got core=%b want 1", bus.core_resetn_o);
        end
        tick(1);
        checks++;
        if (bus.fall_o !== 4'h1 || bus.core_resetn_o !== 1'b0) begin
            errors++;
            $display("FAIL resetgen_assert got fall=%h core=%b want 1 0", bus.fall_o, bus.core_resetn_o);
        end
        tick(1);
        $display("test_resetgen done checks=%0d errors=%0d", checks, errors);
    endtask
`endif

    initial begin
        bus.sw_i = 4'h0;
        test_reset();
        test_clean_edge();
        test_glitch();
        test_simultaneous();
        test_reset_mid_count();
`ifdef SW_DEBOUNCE_RESETGEN_EN
        test_resetgen();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sw_debounce.md
Name: sw_debounce

Overview:
- Input-side conditioner for the board switches; the counterpart to the LED output path.
- Synchronises raw sw pins into the core clock domain and debounces each bit with a stability counter.
- Emits clean levels plus one-cycle rise/fall pulses.
- Sits between the top-level switch pins and the core/peripherals, for example the core resetn and single-step requests.

Parameters:
- N_SW, 4: number of switch inputs.
- DEBOUNCE_CYCLES, 50000: cycles a synchronised input must hold a new value before it is accepted. 50000 is 1 ms at 50 MHz. Legal range ≥2.
- RESET_HOLD, 16: cycles sw_o[0] must stay high before core_resetn_o releases. Used only with the optional feature.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- sw_i  in  N_SW  raw asynchronous switch pins.
- sw_o  out  N_SW  debounced switch levels.
- rise_o  out  N_SW  one-cycle pulse per bit when sw_o bit goes 0→1.
- fall_o  out  N_SW  one-cycle pulse per bit when sw_o bit goes 1→0.
- changed_o  out  1  OR of all rise_o and fall_o bits, same cycle.
- core_resetn_o  out  1  stretched core reset. Present only when SW_DEBOUNCE_RESETGEN_EN is defined.

Behaviour:
- Reset is asynchronous and active-low on resetn, single clock clk. While resetn=0:
  - sync flops, counters, sw_o, rise_o, fall_o and changed_o are all 0.
  - core_resetn_o is 0.
- Synchroniser: two flops per bit, s1 then s2; s2 is the synchronised value. All logic after s2 is on clk.
- Per-bit counter: width $clog2(DEBOUNCE_CYCLES).
  - If s2 == sw_o bit: counter cleared to 0.
  - Else if counter == DEBOUNCE_CYCLES-1: sw_o bit <= s2, counter <= 0, and the matching rise/fall pulse is registered high for exactly that one cycle, coincident with the sw_o change.
  - Else: counter increments.
- Glitch rejection: any return of s2 to the current sw_o value before the terminal count clears the counter. A later attempt restarts from 0.
- Latency: a clean edge on sw_i appears on sw_o and its pulse 2 + DEBOUNCE_CYCLES cycles after the first clk edge that samples it. There is ±1 cycle metastability uncertainty from the synchroniser.
- Bits are independent:
  - Simultaneous transitions on several bits produce simultaneous pulses.
  - changed_o is high if any bit pulses.
- rise_o and fall_o are never both high on the same bit. Pulses never last longer than 1 cycle.
- Power-up with a switch held high: sw_o rises after 2 + DEBOUNCE_CYCLES cycles and a rise pulse is issued. Downstream must tolerate this.
- Reset mid-count: the counter and sync state are lost. Debounce restarts from sw_o=0 after resetn deasserts.

Optional Feature:
- Macro: SW_DEBOUNCE_RESETGEN_EN.
- Defined: adds port core_resetn_o, driven by a hold counter of width $clog2(RESET_HOLD+1).
  - While sw_o[0]=0: hold counter = 0 and core_resetn_o = 0. Assertion follows fall_o[0] in the same cycle, registered.
  - While sw_o[0]=1: the hold counter increments and saturates at RESET_HOLD.
  - core_resetn_o = 1 only once the hold counter == RESET_HOLD. Deassertion is always synchronous to clk.
- Undefined: the port and the hold counter are absent. sw_o[0] is used directly by the integrator.

Decomposition:
- Package sw_pkg holds:
  - default DEBOUNCE_CYCLES and RESET_HOLD constants;
  - a counter-width helper constant function (clog2 wrapper).
- Natural sub-module: sw_debounce_bit (synchroniser + counter + stable flop + rise/fall pulse for one bit), instantiated N_SW times via generate.
- The top level adds changed_o reduction and the optional reset generator.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, RESET_HOLD=3.
- Reset: hold resetn=0 with sw_i=4'hF → all outputs 0. Release → sw_o=4'hF at cycle 6, rise_o=4'hF for one cycle, changed_o=1 for one cycle.
- Clean edge: sw_i[1] 0→1 held → sw_o[1]=1 exactly 6 cycles later, rise_o[1] single pulse. Later 1→0 → fall_o[1] single pulse after 6 cycles.
- Glitch: sw_i[2] high for 3 cycles, then low → sw_o[2] stays 0, no pulse. Bounce pattern 1,0,1,1,1,1,1 → sw_o[2] rises 6 cycles after the last 0→1.
- Simultaneous: sw_i 4'h0→4'h5 in one cycle → rise_o=4'h5 in one cycle, changed_o=1 for one cycle.
- Reset mid-count: sw_i[3] high for 3 cycles, pulse resetn low for 1 cycle → sw_o[3] rises 6 cycles after resetn release, not earlier.
- SW_DEBOUNCE_RESETGEN_EN: sw_i[0] 0→1 → core_resetn_o=1 three cycles after sw_o[0] rises. sw_i[0] 1→0 → core_resetn_o=0 in the same cycle as fall_o[0].
